// File: rtl/adder_pipe_pkg.sv
// Shared defaults and sizing helper for the pipelined chunked adder.
package adder_pipe_pkg;

    localparam int unsigned ADDER_PIPE_DEF_WIDTH  = 16;
    localparam int unsigned ADDER_PIPE_DEF_STAGES = 4;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// Parametrised combinational ripple-carry adder; overflow is the carry out of the MSB.
module adder_nbit #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    logic [BIT_WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = carry_in;
        for (int unsigned i = 0; i < BIT_WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign overflow = carry[BIT_WIDTH];

endmodule

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: adds operand bits [LO+CHUNK-1:LO] and registers valid, carry,
// the accumulated low sum bits and the operand bits still to be added downstream.
module adder_pipe_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned LO    = 0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] psum_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] psum_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    localparam int unsigned HI = LO + CHUNK;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_carry;
    logic [HI-1:0]    psum_d;
    logic [HI-1:0]    psum_q;
    logic             valid_q;
    logic             carry_q;
    logic             data_en;

    // Bubbles never touch the data, so the outputs keep their last valid result.
    assign data_en = load_i && valid_i;

    adder_nbit #(.BIT_WIDTH(CHUNK)) u_add (
        .a        (a_i[HI-1:LO]),
        .b        (b_i[HI-1:LO]),
        .carry_in (carry_i),
        .sum      (chunk_sum),
        .overflow (chunk_carry)
    );

    if (LO == 0) begin : g_first
        logic unused_psum;
        assign psum_d      = chunk_sum;
        assign unused_psum = ^psum_i;
    end else begin : g_chain
        logic unused_low;
        assign psum_d     = {chunk_sum, psum_i[LO-1:0]};
        assign unused_low = ^{psum_i[WIDTH-1:LO], a_i[LO-1:0], b_i[LO-1:0]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            psum_q  <= '0;
        end else begin
            if (load_i) begin
                valid_q <= valid_i;
            end
            if (data_en) begin
                carry_q <= chunk_carry;
                psum_q  <= psum_d;
            end
        end
    end

    if (HI < WIDTH) begin : g_ops
        logic [WIDTH-1:HI] a_q;
        logic [WIDTH-1:HI] b_q;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (data_en) begin
                a_q <= a_i[WIDTH-1:HI];
                b_q <= b_i[WIDTH-1:HI];
            end
        end

        assign a_o    = {a_q, {HI{1'b0}}};
        assign b_o    = {b_q, {HI{1'b0}}};
        assign psum_o = {{(WIDTH-HI){1'b0}}, psum_q};
    end else begin : g_last
        assign a_o    = '0;
        assign b_o    = '0;
        assign psum_o = psum_q;
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined chunked adder with valid/ready on both sides and per-stage bubble collapsing.
// Build option: ADDER_PIPE_SATURATE_EN clamps sum to all-ones on carry out of the MSB.
module adder_pipe_nbit
    import adder_pipe_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = ADDER_PIPE_DEF_WIDTH,
    parameter int unsigned NUM_STAGES = ADDER_PIPE_DEF_STAGES
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    localparam int unsigned CHUNK = chunk_width(BIT_WIDTH, NUM_STAGES);

    if ((NUM_STAGES == 0) || ((BIT_WIDTH % NUM_STAGES) != 0)) begin : g_cfg_err
        $error("adder_pipe_nbit: BIT_WIDTH (%0d) must be a multiple of NUM_STAGES (%0d)",
               BIT_WIDTH, NUM_STAGES);
    end

    logic [NUM_STAGES-1:0] valid_s;
    logic [NUM_STAGES-1:0] carry_s;
    logic [NUM_STAGES-1:0] accept;
    logic [BIT_WIDTH-1:0]  psum_s [NUM_STAGES];
    logic [BIT_WIDTH-1:0]  a_s    [NUM_STAGES];
    logic [BIT_WIDTH-1:0]  b_s    [NUM_STAGES];
    logic                  unused_tail;

    // Walk from the output back to stage 0: a stage loads if empty or its successor loads.
    always_comb begin
        accept = '0;
        accept[NUM_STAGES-1] = !valid_s[NUM_STAGES-1] || out_ready;
        for (int unsigned j = 1; j < NUM_STAGES; j++) begin
            accept[NUM_STAGES-1-j] = !valid_s[NUM_STAGES-1-j] || accept[NUM_STAGES-j];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                 valid_in;
        logic                 carry_k;
        logic [BIT_WIDTH-1:0] psum_in;
        logic [BIT_WIDTH-1:0] a_in;
        logic [BIT_WIDTH-1:0] b_in;

        if (k == 0) begin : g_src
            assign valid_in = in_valid;
            assign carry_k  = carry_in;
            assign psum_in  = '0;
            assign a_in     = a;
            assign b_in     = b;
        end else begin : g_link
            assign valid_in = valid_s[k-1];
            assign carry_k  = carry_s[k-1];
            assign psum_in  = psum_s[k-1];
            assign a_in     = a_s[k-1];
            assign b_in     = b_s[k-1];
        end

        adder_pipe_stage #(
            .WIDTH (BIT_WIDTH),
            .CHUNK (CHUNK),
            .LO    (k * CHUNK)
        ) u_stage (
            .clk     (clk),
            .n_rst   (n_rst),
            .load_i  (accept[k]),
            .valid_i (valid_in),
            .carry_i (carry_k),
            .psum_i  (psum_in),
            .a_i     (a_in),
            .b_i     (b_in),
            .valid_o (valid_s[k]),
            .carry_o (carry_s[k]),
            .psum_o  (psum_s[k]),
            .a_o     (a_s[k]),
            .b_o     (b_s[k])
        );
    end

    assign unused_tail = ^{a_s[NUM_STAGES-1], b_s[NUM_STAGES-1]};

    assign in_ready  = accept[0];
    assign out_valid = valid_s[NUM_STAGES-1];
    assign overflow  = carry_s[NUM_STAGES-1];

`ifdef ADDER_PIPE_SATURATE_EN
    assign sum = carry_s[NUM_STAGES-1] ? '1 : psum_s[NUM_STAGES-1];
`else
    assign sum = psum_s[NUM_STAGES-1];
`endif

endmodule
